// File: rtl/mips32_prog_loader.sv
// rtl/mips32_prog_loader.sv - host-side command loader: program/data load, run control, memory dump
`timescale 1ns/1ps
module mips32_prog_loader #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int MAX_RUN = 1024,
  parameter int CNT_W   = 13
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              mem_sel,
  output logic              mem_we,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic              bad_cmd
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_DUMP_RD, S_DUMP_WAIT, S_DUMP_OUT
  } state_t;

  state_t            state, state_nxt;
  logic [2:0]        op;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [ADDR_W-1:0] hdr_base;
  logic              unused_hdr;
  logic [CNT_W-1:0]  cnt_r, k;
  logic [ADDR_W-1:0] ptr, wr_addr;
  logic [RUN_W-1:0]  run_cnt;
  logic              sel;
  logic              last_word;
  logic              run_limit;

  assign op         = cmd_data[31:29];
  assign hdr_cnt    = cmd_data[16 +: CNT_W];
  assign hdr_base   = cmd_data[ADDR_W-1:0];
  assign unused_hdr = ^cmd_data[15:ADDR_W];
  assign last_word  = (k + CNT_W'(1)) == cnt_r;
  assign run_limit  = run_cnt == RUN_W'(MAX_RUN - 1);
  assign mem_sel    = sel;

  always_ff @(posedge clk1) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op)
            3'b000, 3'b001: state_nxt = (hdr_cnt == '0) ? S_IDLE : S_LOAD;
            3'b010:         state_nxt = S_RUN;
            3'b011, 3'b100: state_nxt = (hdr_cnt == '0) ? S_IDLE : S_DUMP_RD;
            default:        state_nxt = S_IDLE;
          endcase
        end
      end
      S_LOAD:      if (cmd_valid && last_word) state_nxt = S_IDLE;
      S_RUN:       if (cpu_halted || run_limit) state_nxt = S_IDLE;
      S_DUMP_RD:   state_nxt = S_DUMP_WAIT;
      S_DUMP_WAIT: state_nxt = S_DUMP_OUT;
      S_DUMP_OUT:  if (out_ready) state_nxt = last_word ? S_IDLE : S_DUMP_RD;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE) || (state == S_LOAD);
    busy      = state != S_IDLE;
    cpu_run   = state == S_RUN;
    mem_re    = state == S_DUMP_RD;
    out_valid = state == S_DUMP_OUT;
    mem_addr  = (state == S_DUMP_RD) ? ptr : wr_addr;
  end

  // ptr walks base+k modulo the memory depth for both loads and dumps
  always_ff @(posedge clk1) begin
    if (rst) begin
      sel       <= 1'b0;
      cnt_r     <= '0;
      k         <= '0;
      ptr       <= '0;
      wr_addr   <= '0;
      run_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      out_data  <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      bad_cmd   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            case (op)
              3'b000, 3'b001, 3'b011, 3'b100: begin
                sel   <= (op == 3'b001) || (op == 3'b100);
                cnt_r <= hdr_cnt;
                ptr   <= hdr_base;
                k     <= '0;
              end
              3'b010: begin
                done    <= 1'b0;
                timeout <= 1'b0;
                run_cnt <= '0;
              end
              default: bad_cmd <= 1'b1;
            endcase
          end
        end
        S_LOAD: begin
          if (cmd_valid) begin
            mem_we    <= 1'b1;
            wr_addr   <= ptr;
            mem_wdata <= cmd_data;
            ptr       <= ptr + ADDR_W'(1);
            k         <= k + CNT_W'(1);
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + RUN_W'(1);
          if (cpu_halted)     done    <= 1'b1;
          else if (run_limit) timeout <= 1'b1;
        end
        S_DUMP_WAIT: out_data <= mem_rdata;
        S_DUMP_OUT: begin
          if (out_ready) begin
            ptr <= ptr + ADDR_W'(1);
            k   <= k + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// tb/tb_mips32_prog_loader.sv - scoreboard bench for mips32_prog_loader with memory and core models
`timescale 1ns/1ps
module tb_mips32_prog_loader;

  logic        clk1 = 1'b0;
  logic        rst, cmd_valid, cmd_ready, mem_sel, mem_we, mem_re, cpu_run, cpu_halted;
  logic        out_valid, out_ready, busy, done, timeout, bad_cmd;
  logic [31:0] cmd_data, mem_wdata, mem_rdata, out_data;
  logic [7:0]  mem_addr;

  mips32_prog_loader #(.DATA_W(32), .ADDR_W(8), .MAX_RUN(16), .CNT_W(13)) dut (
    .clk1(clk1), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .mem_sel(mem_sel), .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .done(done), .timeout(timeout), .bad_cmd(bad_cmd)
  );

  always #5 clk1 = ~clk1;

  int checks = 0;
  int errors = 0;
  int ready_mode = 1;
  int core_mode = 0;
  int run_age = 0;
  int run_cycles = 0;
  int halt_overlap = 0;
  int re_count = 0;
  logic        core_fire = 1'b0;
  logic        hold = 1'b0;
  logic [31:0] hold_data;

  logic [31:0] env_mem [2][256];
  logic [31:0] ref_mem [2][256];
  logic [40:0] exp_wr [$];
  logic [31:0] exp_out [$];
  logic [31:0] wq [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr(input logic [2:0] op, input int cnt, input int base);
    logic [31:0] c, b;
    c = cnt;
    b = base;
    return {op, c[12:0], b[15:0]};
  endfunction

  // memory behind the loader: one-cycle read latency; the core model's store lands here too
  always @(posedge clk1) begin
    if (mem_we) env_mem[mem_sel][mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= env_mem[mem_sel][mem_addr];
    if (core_fire) env_mem[1][121] <= env_mem[1][120] + 32'd45;
  end

  // core model: the loaded program stores mem[120]+45 at mem[121] then halts
  always @(posedge clk1) begin
    #1;
    core_fire = 1'b0;
    if (!cpu_run) begin
      run_age = 0;
      cpu_halted = 1'b0;
    end else begin
      run_age++;
      if (core_mode == 1 && run_age == 6) begin
        cpu_halted = 1'b1;
        core_fire = 1'b1;
      end
    end
  end

  always @(posedge clk1) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom % 2);
    endcase
  end

  always @(negedge clk1) begin
    logic [40:0] e;
    if (rst) begin
      hold = 1'b0;
    end else begin
      chk("we_re_exclusive", 32'(mem_we && mem_re), 0);
      chk("strobe_while_run", 32'((mem_we || mem_re) && cpu_run), 0);
      if (mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_wr.pop_front();
          chk("wr_sel", 32'(mem_sel), 32'(e[40]));
          chk("wr_addr", 32'(mem_addr), 32'(e[39:32]));
          chk("wr_data", mem_wdata, e[31:0]);
        end
      end
      if (mem_re) re_count++;
      if (hold && out_valid) chk("out_stable", out_data, hold_data);
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) chk("unexpected_dump", 1, 0);
        else chk("dump_data", out_data, exp_out.pop_front());
      end
      hold = out_valid && !out_ready;
      hold_data = out_data;
      if (cpu_run) run_cycles++;
      if (cpu_run && cpu_halted) halt_overlap++;
    end
  end

  task automatic send(input logic [31:0] w);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_data = w;
    @(negedge clk1);
    while (!cmd_ready && n < 200) begin
      @(negedge clk1);
      n++;
    end
    if (!cmd_ready) chk("cmd_ready_timeout", 0, 1);
    @(posedge clk1);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    @(negedge clk1);
    while (busy && n < limit) begin
      @(negedge clk1);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk1);
    @(posedge clk1);
    #1;
  endtask

  task automatic do_load(input logic sel, input int base);
    int a;
    send(hdr(sel ? 3'b001 : 3'b000, wq.size(), base));
    foreach (wq[i]) begin
      a = (base + i) % 256;
      exp_wr.push_back({sel, 8'(a), wq[i]});
      ref_mem[sel][a] = wq[i];
      send(wq[i]);
    end
    wait_idle(100);
    chk("wr_queue_drained", exp_wr.size(), 0);
  endtask

  task automatic do_dump(input logic sel, input int base, input int cnt);
    for (int i = 0; i < cnt; i++) exp_out.push_back(ref_mem[sel][(base + i) % 256]);
    send(hdr(sel ? 3'b100 : 3'b011, cnt, base));
    wait_idle(100 * cnt + 100);
    chk("dump_queue_drained", exp_out.size(), 0);
  endtask

  task automatic do_run();
    send(hdr(3'b010, 0, 0));
    wait_idle(200);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int re0, base, n, sel;
    logic [31:0] prog [8];
    prog = '{32'h28010078, 32'h0c631800, 32'h20220000, 32'h0c631800,
             32'h2842002d, 32'h0c631800, 32'h24220001, 32'hfc000000};
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_data = '0;
    repeat (3) @(posedge clk1);
    #1;
    rst = 1'b0;
    @(negedge clk1);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({mem_we, mem_re, cpu_run, out_valid}), 0);
    chk("rst_flags", 32'({done, timeout, bad_cmd}), 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk1);
    #1;

    wq.delete();
    foreach (prog[i]) wq.push_back(prog[i]);
    do_load(1'b0, 0);

    ready_mode = 0;
    send(hdr(3'b011, 8, 0));
    n = 0;
    @(negedge clk1);
    while (!out_valid && n < 50) begin
      @(negedge clk1);
      n++;
    end
    chk("t1_out_valid_seen", 32'(out_valid), 1);
    rst = 1'b1;
    @(posedge clk1);
    #1;
    rst = 1'b0;
    @(negedge clk1);
    chk("t1_out_valid_after_rst", 32'(out_valid), 0);
    chk("t1_busy_after_rst", 32'(busy), 0);
    chk("t1_cmd_ready_after_rst", 32'(cmd_ready), 1);
    @(posedge clk1);
    #1;
    ready_mode = 2;
    do_dump(1'b0, 0, 8);
    ready_mode = 1;

    wq.delete();
    wq.push_back(32'h00000055);
    do_load(1'b1, 120);
    core_mode = 1;
    run_cycles = 0;
    halt_overlap = 0;
    do_run();
    chk("t3_done", 32'(done), 1);
    chk("t3_timeout", 32'(timeout), 0);
    chk("t3_halt_to_drop", 32'(halt_overlap <= 1), 1);
    ref_mem[1][121] = ref_mem[1][120] + 32'd45;
    do_dump(1'b1, 120, 2);

    core_mode = 0;
    run_cycles = 0;
    do_run();
    chk("t4_run_cycles", 32'(run_cycles), 16);
    chk("t4_timeout", 32'(timeout), 1);
    chk("t4_done", 32'(done), 0);

    ready_mode = 2;
    wq.delete();
    repeat (4) wq.push_back($urandom);
    do_load(1'b1, 254);
    do_dump(1'b1, 254, 4);

    re0 = re_count;
    send(hdr(3'b110, 3, 5));
    repeat (3) @(negedge clk1);
    chk("t6_bad_cmd", 32'(bad_cmd), 1);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_no_read", re_count, re0);
    @(posedge clk1);
    #1;
    wq.delete();
    repeat (2) wq.push_back($urandom);
    do_load(1'b0, 10);
    do_dump(1'b0, 10, 2);

    for (int it = 0; it < 8; it++) begin
      sel = $urandom_range(1);
      base = $urandom_range(255);
      n = $urandom_range(5);
      wq.delete();
      repeat (n) wq.push_back($urandom);
      do_load(1'(sel), base);
      do_dump(1'(sel), base, n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
